riscv_dmem_resp: RTL
====================

# riscv_dmem_resp

Handshaked data-memory responder that sits on the memory side of the pipeline's load/store path. It accepts one request at a time from a memory-stage initiator: a word address, byte-lane select, store data and a load-signedness flag. It commits stores with byte-lane enables. For loads it returns a lane-extracted, sign- or zero-extended `XLEN` word after a fixed latency. This lets the memory stage target multi-cycle memory instead of the single-cycle `riscv_dmem`.

## Interface
- `XLEN`, 32: data width.
- `ADDR_BIT`, 12: byte-address width. Depth is 2^(`ADDR_BIT`-2) words.
- `RD_LAT`, 2: load latency in cycles, accept edge to response. Legal range 1..15.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  responder can accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_addr`  in  `ADDR_BIT`  byte address.
- `i_req_wdata`  in  `XLEN`  store data, right-aligned (byte/half in low bits).
- `i_req_bsel`  in  4  size mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
- `i_req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  initiator takes the response.
- `o_rsp_rdata`  out  `XLEN`  load data; 0 for stores.
- `o_rsp_err`  out  1  misaligned-access flag (see Configuration).

## Operation
- States are IDLE, WAIT and RESP. Reset enters IDLE.
- IDLE:
  - `o_req_ready`=1.
  - On `i_req_valid`&`o_req_ready` (accept), latch `i_req_addr[1:0]`, `i_req_bsel` and `i_req_unsigned`.
- Store on accept:
  - Lane mask = `i_req_bsel` << addr[1:0], truncated to 4 bits.
  - Write data = `i_req_wdata` << (8·addr[1:0]).
  - Only masked bytes of word `i_req_addr[ADDR_BIT-1:2]` are written, at the accept edge.
  - Next state is RESP.
- Load on accept:
  - Read the whole word at the accept edge into a holding register.
  - Load a down-counter with `RD_LAT`-1.
  - Next state is WAIT, or RESP directly if `RD_LAT`=1.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP:
  - `o_rsp_valid`=1.
  - Load data = held word >> (8·addr[1:0]), masked to the size, then sign- or zero-extended from bit 7 or 15. Word loads pass through unchanged.
  - On `i_rsp_ready`, go to IDLE. Until then, `o_rsp_rdata` and `o_rsp_err` hold stable.
- Memory contents are never reset or initialised by this block.

## Timing
- Reset values:
  - `o_req_ready`=1, `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0.
  - Counter=0, state=IDLE.
- All outputs are registered. There is no combinational path from `i_req_*` or `i_rsp_ready` to any output.
- Store response: `o_rsp_valid` rises 1 cycle after the accept edge.
- Load response: `o_rsp_valid` rises `RD_LAT` cycles after the accept edge.
- `o_req_ready` is 0 in WAIT and RESP. Throughput is therefore at most one request per (latency+1) cycles with `i_rsp_ready` held high. There is no same-cycle response-and-accept.
- `i_req_valid` while not ready is ignored. The initiator must hold its request.
- Reset mid-operation:
  - An accepted store is already committed.
  - A pending load or response is dropped. `o_rsp_valid` clears asynchronously and the FSM returns to IDLE.
- A store followed by a load to the same word returns the new data, since the write is committed before the next accept.

## Configuration
- `DMEM_MISALIGN_ERR_EN`, when defined: an access is misaligned if (`i_req_bsel` << addr[1:0]) has bits beyond lane 3, or if it is a word access with addr[1:0]≠0. For such an access:
  - No bytes are written.
  - The response carries `o_rsp_err`=1 and `o_rsp_rdata`=0.
  - Latency is unchanged.
- When undefined: `o_rsp_err` is tied 0. Out-of-word lanes are silently dropped, so only in-word bytes are written. Loads return the shifted, truncated data with extension applied as normal.

## Test plan
- Reset, then idle: `o_req_ready`=1, `o_rsp_valid`=0 and `o_rsp_rdata`=0 for 10 cycles. Assert `i_rst` mid-WAIT: `o_rsp_valid` stays 0 and `o_req_ready` returns to 1.
- Store word 32'hDEADBEEF to 0x010, then load word 0x010 with `RD_LAT`=2: the store response arrives 1 cycle after accept, and the load returns 32'hDEADBEEF exactly 2 cycles after accept.
- Store byte 8'h80 to 0x013, then load byte 0x013: signed returns 32'hFFFFFF80, unsigned returns 32'h00000080, and the word at 0x010 reads 32'h80ADBEEF.
- Store half 16'h8001 to 0x022, then load half 0x022: signed returns 32'hFFFF8001, and the low half of the word at 0x020 is unchanged.
- Backpressure: hold `i_rsp_ready`=0 for 5 cycles in RESP. `o_rsp_rdata` stays stable, `o_req_ready` stays 0, and a new `i_req_valid` is not accepted until after the handshake.
- With `DMEM_MISALIGN_ERR_EN`: store half to 0x013 gives `o_rsp_err`=1 and the word at 0x010 is unchanged. Without the macro: `o_rsp_err`=0, and only byte 3 is written.

Source files
------------

// File: rtl/riscv_dmem_resp.sv
// ---------------------------------------------------------------------------------------------
// riscv_dmem_resp
//
// Handshaked data-memory responder for the memory stage of the load/store path. It accepts one
// request at a time. Stores are committed with byte-lane enables at the accept edge. Loads read
// the whole word at the accept edge. After RD_LAT cycles the responder returns the word
// lane-extracted and sign- or zero-extended to XLEN bits.
//
// Parameters
//   XLEN      data width (lane logic is built for four 8-bit lanes, i.e. XLEN = 32)
//   ADDR_BIT  byte-address width; depth is 2**(ADDR_BIT-2) words
//   RD_LAT    load latency, accept edge to response, legal range 1..15
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_req_valid     request present
//   o_req_ready     responder idle and able to accept
//   i_req_we        1 = store, 0 = load
//   i_req_addr      byte address
//   i_req_wdata     store data, right-aligned
//   i_req_bsel      size mask: 0001 byte, 0011 half, 1111 word
//   i_req_unsigned  load zero-extends when 1, sign-extends when 0
//   o_rsp_valid     response present
//   i_rsp_ready     initiator takes the response
//   o_rsp_rdata     load data, 0 for stores
//   o_rsp_err       misaligned-access flag
//
// Optional feature
//   DMEM_MISALIGN_ERR_EN  when defined, accesses that spill past lane 3 (or word accesses with a
//                         non-zero byte offset) write nothing and respond with o_rsp_err = 1 and
//                         o_rsp_rdata = 0. When undefined, o_rsp_err is always 0 and out-of-word
//                         lanes are silently dropped.
// ---------------------------------------------------------------------------------------------
module riscv_dmem_resp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_BIT = 12,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [ADDR_BIT-1:0] i_req_addr,
    input  logic [XLEN-1:0]     i_req_wdata,
    input  logic [3:0]          i_req_bsel,
    input  logic                i_req_unsigned,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_rdata,
    output logic                o_rsp_err
);

    localparam int unsigned WordAw  = ADDR_BIT - 2;
    localparam int unsigned Depth   = 2 ** WordAw;
    localparam logic [3:0]  CntInit = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Request fields captured at the accept edge
    logic [1:0]      off_q;
    logic [3:0]      bsel_q;
    logic            uns_q;
    logic            mis_q;
    logic [XLEN-1:0] hold_q;

    // Registered outputs
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [XLEN-1:0] mem [Depth];

    // ------------------------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------------------------
    logic              accept;
    logic [WordAw-1:0] word_idx;
    logic [1:0]        off_i;
    logic [7:0]        lane_ext;
    logic [3:0]        lane_mask;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   mem_rd;
    logic              mis_i;
    logic [3:0]        we_lanes;

    assign accept    = i_req_valid & req_ready_q;
    assign word_idx  = i_req_addr[ADDR_BIT-1:2];
    assign off_i     = i_req_addr[1:0];
    // Eight bits wide so lanes pushed past lane 3 remain visible for the misalign check
    assign lane_ext  = {4'b0000, i_req_bsel} << off_i;
    assign lane_mask = lane_ext[3:0];
    assign wdata_sh  = i_req_wdata << {off_i, 3'b000};
    assign mem_rd    = mem[word_idx];

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_i = (|lane_ext[7:4]) | ((i_req_bsel == 4'b1111) & (off_i != 2'd0));
`else
    assign mis_i = 1'b0;
`endif

    assign we_lanes = lane_mask & {4{accept & i_req_we & ~mis_i}};

    // ------------------------------------------------------------------------------------------
    // Storage: never reset, written only at a store's accept edge
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_lanes[b]) begin
                mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // Shift the addressed lane down, then size-mask and extend. Word accesses pass through.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word_v,
                                                input logic [1:0]      off_v,
                                                input logic [3:0]      bsel_v,
                                                input logic            uns_v);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = word_v >> {off_v, 3'b000};
        if (bsel_v[3]) begin
            res = sh;
        end else if (bsel_v[1]) begin
            res = {{(XLEN-16){~uns_v & sh[15]}}, sh[15:0]};
        end else begin
            res = {{(XLEN-8){~uns_v & sh[7]}}, sh[7:0]};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request capture; the held word is the pre-write contents, only used by loads
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            off_q  <= 2'd0;
            bsel_q <= 4'd0;
            uns_q  <= 1'b0;
            mis_q  <= 1'b0;
            hold_q <= '0;
        end else if (accept) begin
            off_q  <= off_i;
            bsel_q <= i_req_bsel;
            uns_q  <= i_req_unsigned;
            mis_q  <= mis_i;
            hold_q <= mem_rd;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (i_req_we || (RD_LAT == 1)) begin
                        state_d = StResp;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------------------------
    // Output logic: next values of the output registers, derived from the upcoming state
    // ------------------------------------------------------------------------------------------
    always_comb begin
        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (state_d == StResp) begin
            unique case (state_q)
                StResp: begin
                    // Hold stable while the initiator applies backpressure
                    rsp_rdata_d = rsp_rdata_q;
                    rsp_err_d   = rsp_err_q;
                end
                StIdle: begin
                    // Store, or a single-cycle load straight from the array
                    rsp_err_d = mis_i;
                    if (!i_req_we && !mis_i) begin
                        rsp_rdata_d = extract(mem_rd, off_i, i_req_bsel, i_req_unsigned);
                    end
                end
                default: begin
                    rsp_err_d = mis_q;
                    if (!mis_q) begin
                        rsp_rdata_d = extract(hold_q, off_q, bsel_q, uns_q);
                    end
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule
